// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory and
// latches returned words into the IR, with redirect, stall, halt and fault.
module fetch_unit #(
    parameter int                ADDR_W      = 20,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                MEM_SIZE    = 150,
    parameter logic [5:0]        HALT_OPCODE = 6'd11
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] imem_address,
    input  logic [DATA_W-1:0] imem_instruction,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              stall,
    input  logic              resume,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_instruction,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(MEM_SIZE);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              is_halt;

    assign imem_address = pc;
    assign is_halt      = imem_instruction[DATA_W-1 -: 6] == HALT_OPCODE;
    assign halted       = state == HALT;
    assign fault        = state == FAULT;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RUN;
            pc             <= RESET_PC;
            ir_valid       <= 1'b0;
            ir_instruction <= '0;
            ir_pc          <= '0;
            fetch_count    <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    // Redirect outranks the range check so a bad target
                    // is only reported once it has become the pc.
                    if (redirect_valid) begin
                        pc       <= redirect_target;
                        ir_valid <= 1'b0;
                    end else if (pc >= PC_LIMIT) begin
                        state    <= FAULT;
                        ir_valid <= 1'b0;
                    end else if (!stall) begin
                        ir_instruction <= imem_instruction;
                        ir_pc          <= pc;
                        ir_valid       <= 1'b1;
                        pc             <= pc + 1'b1;
                        if (fetch_count != '1)
                            fetch_count <= fetch_count + 32'd1;
                        if (is_halt)
                            state <= HALT;
                    end
                end
                HALT: begin
                    // The halt word is shown once, then the IR empties.
                    if (!stall)
                        ir_valid <= 1'b0;
                    if (resume)
                        state <= RUN;
                end
                FAULT: begin
                    ir_valid <= 1'b0;
                end
                default: begin
                    state    <= FAULT;
                    ir_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
